multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

RV32I-style datapath executing each instruction over several clock cycles, with parametrised width, instruction-ROM depth and reset vector. Instruction and data memories are reached through req/ready handshakes that tolerate wait states. The block replaces the single-cycle datapath beneath the existing control decoder: it exports opcode/func3/func7 from a latched instruction register and takes back the same control flags, plus MemRead/MemWrite.

## Interface
- XLEN, 32: datapath and register width.
- ROM_AW, 8: instruction-ROM word-address width; rom_addr = pc[ROM_AW+1:2].
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- instr  in  32  ROM read data, valid when imem_ready=1.
- imem_req  out  1  fetch request.
- imem_ready  in  1  fetch complete this cycle.
- rom_addr  out  ROM_AW  instruction word address.
- MemtoReg, ALUSrc, RegWrite, lui, U_type, jal, jalr, beq, bne, blt, bge, bltu, bgeu  in  1 each  decoder flags, same meaning as in the single-cycle core.
- MemRead, MemWrite  in  1  load / store flags.
- ALUctl  in  4  ALU operation select.
- opcode  out  7, func3  out  3, func7  out  1  fields of IR.
- dmem_req  out  1  data access request; dmem_we  out  1  write when 1.
- dmem_ready  in  1  data access complete this cycle.
- ALU_result  out  XLEN  latched ALUOut, used as data address.
- Wr_mem_data  out  XLEN  latched rs2 value.
- Rd_mem_data  in  XLEN  load data, valid with dmem_ready.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- pc  out  XLEN  current architectural PC.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: imem_req=1. On imem_ready: IR<=instr, PCn<=pc+4, go DECODE. Otherwise hold.
- DECODE: A<=rs1 data, B<=rs2 data, IMM<=decoded immediate, go EXEC.
- EXEC: ALUOut<=ALU(A, ALUSrc?IMM:B), branch flag evaluated from zero/sign as in branch_judge. Next state:
  - MemRead|MemWrite: go MEM.
  - Conditional branch: PC update, go FETCH.
  - Otherwise: go WB.
- MEM: dmem_req=1, dmem_we=MemWrite. On dmem_ready:
  - Load: MDR<=Rd_mem_data, go WB.
  - Store: PC update, go FETCH.
- WB: register write when RegWrite.
  - Write data priority: U_type ? (lui ? IMM : pc+IMM); else jal|jalr ? PCn; else MemtoReg ? MDR : ALUOut.
  - Then PC update, go FETCH.
- PC update happens exactly once per instruction, at its final state:
  - jalr: {ALUOut[XLEN-1:1],0}.
  - jal or taken branch: pc+IMM.
  - Otherwise: PCn.
- instr_retired pulses in the same cycle as the PC update.
- Writes to x0 are discarded.
- All adders wrap modulo 2^XLEN; no overflow trap.

## Timing
- Reset values: state FETCH, pc=RESET_PC, IR=0, ALUOut=0, B=0, MDR=0, imem_req=0, dmem_req=0, dmem_we=0, instr_retired=0. imem_req rises the cycle after rst deasserts.
- Cycles with zero wait states:
  - Conditional branch: 3.
  - ALU, U-type, jal, jalr, store: 4.
  - Load: 5.
- Each imem/dmem wait cycle adds one cycle. While waiting, req and the address/data/we outputs stay constant.
- Handshake completes in any cycle where req=1 and ready=1. A ready with req=0 is ignored.
- rst mid-instruction: the next state is FETCH and req drops. Abandoned accesses cause no register or PC update. The memory side must accept a dropped request.
- Register-file read is combinational from IR fields; the write occurs at the WB clock edge. An instruction in DECODE sees all prior writes.

## Structure
- Package datapath_pkg: state enum, opcode constants, ALUctl encodings.
- Sub-module mc_ctrl_fsm: state register, next-state logic, req/we/retired outputs, PC-write and IR-write enables.
- The datapath reuses instr_decode, registers (rst_n driven by ~rst), alu, branch_judge and cla_adder32.

## Test plan
- Reset with RESET_PC=32'h40: pc=0x40, rom_addr=0x10, imem_req=0 during rst and 1 one cycle after. All other outputs are 0.
- addi x1,x0,5 then add x2,x1,x1, ready always 1: x2=10, and instr_retired pulses every 4 cycles.
- sw x2,8(x0) with dmem_ready delayed 3 cycles: dmem_req/dmem_we/ALU_result=8/Wr_mem_data=10 held for 4 cycles, total 7 cycles. Then lw x3,8(x0) loads x3=10 in 5 cycles.
- beq x1,x1,-8 at pc 0x20: next pc=0x18 after 3 cycles. bne on equal operands: next pc=0x24.
- jalr x5,4(x6) with x6=0x101: pc=0x104, x5 = old pc+4. lui x7,0x12345 gives x7=0x12345000.
- rst asserted in the MEM state of a load while dmem_ready=0: no register write, pc=RESET_PC, and the next fetch is issued normally.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for the multicycle RV32I datapath: FSM states,
// major opcodes, ALU operation encodings and the immediate decoder.
package datapath_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Sign-extended 32-bit immediate; I-format is the fallback for everything else.
  function automatic logic [31:0] imm_decode(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OP_STORE:         imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {ir[31:12], 12'b0};
      OP_JAL:           imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:          imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Sequencer for the multicycle datapath: owns the state register, the
// registered memory request strobes and the per-state write enables.
module mc_ctrl_fsm
  import datapath_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   imem_ready,
  input  logic   dmem_ready,
  input  logic   mem_op,
  input  logic   mem_write,
  input  logic   cond_branch,
  output state_t state,
  output logic   imem_req,
  output logic   dmem_req,
  output logic   dmem_we,
  output logic   instr_retired,
  output logic   pc_write,
  output logic   ir_write,
  output logic   mdr_write
);

  state_t state_reg, state_next;
  logic   imem_req_reg, dmem_req_reg, dmem_we_reg, retired_reg;
  logic   imem_done, dmem_done;

  // A ready seen while our request is low is not a handshake.
  assign imem_done = (state_reg == S_FETCH) && imem_req_reg && imem_ready;
  assign dmem_done = (state_reg == S_MEM) && dmem_req_reg && dmem_ready;

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (imem_done) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (mem_op) begin
          state_next = S_MEM;
        end else if (cond_branch) begin
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_done) begin
          if (mem_write) begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end else begin
            mdr_write  = 1'b1;
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are registered from the next state so they hold steady through wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      imem_req_reg <= 1'b0;
      dmem_req_reg <= 1'b0;
      dmem_we_reg  <= 1'b0;
      retired_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      imem_req_reg <= (state_next == S_FETCH);
      dmem_req_reg <= (state_next == S_MEM);
      dmem_we_reg  <= (state_next == S_MEM) && mem_write;
      retired_reg  <= pc_write;
    end
  end

  assign state         = state_reg;
  assign imem_req      = imem_req_reg;
  assign dmem_req      = dmem_req_reg;
  assign dmem_we       = dmem_we_reg;
  assign instr_retired = retired_reg;

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath: IR/A/B/IMM/ALUOut/MDR staging registers, register
// file, ALU and branch compare, sequenced by mc_ctrl_fsm under external decode.
module multicycle_datapath
  import datapath_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               ROM_AW   = 8,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              MemtoReg,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic              lui,
  input  logic              U_type,
  input  logic              jal,
  input  logic              jalr,
  input  logic              beq,
  input  logic              bne,
  input  logic              blt,
  input  logic              bge,
  input  logic              bltu,
  input  logic              bgeu,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [3:0]        ALUctl,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic              func7,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic [XLEN-1:0]   ALU_result,
  output logic [XLEN-1:0]   Wr_mem_data,
  input  logic [XLEN-1:0]   Rd_mem_data,
  output logic              instr_retired,
  output logic [XLEN-1:0]   pc
);

  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic            pc_write, ir_write, mdr_write;
  logic [31:0]     ir_reg;
  logic [XLEN-1:0] pc_reg, pcn_reg, a_reg, b_reg, imm_reg, alu_out_reg, mdr_reg;
  logic [XLEN-1:0] rf [32];
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm_ext, alu_b, alu_y;
  logic [XLEN-1:0] pc_plus_imm, pc_next, wb_data;
  logic [SHW-1:0]  shamt;
  logic            cond_branch, br_eq, br_lt, br_ltu, br_taken, rf_write;

  assign cond_branch = beq | bne | blt | bge | bltu | bgeu;

  mc_ctrl_fsm u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .mem_op       (MemRead | MemWrite),
    .mem_write    (MemWrite),
    .cond_branch  (cond_branch),
    .state        (state),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .instr_retired(instr_retired),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .mdr_write    (mdr_write)
  );

  assign rs1      = ir_reg[19:15];
  assign rs2      = ir_reg[24:20];
  assign rd       = ir_reg[11:7];
  assign rs1_data = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign imm_ext  = XLEN'($signed(imm_decode(ir_reg)));

  assign alu_b = ALUSrc ? imm_reg : b_reg;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_y = '0;
    case (ALUctl)
      ALU_ADD:  alu_y = a_reg + alu_b;
      ALU_SUB:  alu_y = a_reg - alu_b;
      ALU_SLL:  alu_y = a_reg << shamt;
      ALU_SLT:  alu_y = XLEN'($signed(a_reg) < $signed(alu_b));
      ALU_SLTU: alu_y = XLEN'(a_reg < alu_b);
      ALU_XOR:  alu_y = a_reg ^ alu_b;
      ALU_SRL:  alu_y = a_reg >> shamt;
      ALU_SRA:  alu_y = $signed(a_reg) >>> shamt;
      ALU_OR:   alu_y = a_reg | alu_b;
      ALU_AND:  alu_y = a_reg & alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Branch outcome is only consumed in EXEC, where A/B hold this instruction's operands.
  assign br_eq    = (a_reg == b_reg);
  assign br_lt    = ($signed(a_reg) < $signed(b_reg));
  assign br_ltu   = (a_reg < b_reg);
  assign br_taken = (beq & br_eq) | (bne & ~br_eq) | (blt & br_lt) |
                    (bge & ~br_lt) | (bltu & br_ltu) | (bgeu & ~br_ltu);

  assign pc_plus_imm = pc_reg + imm_reg;

  always_comb begin
    if (jalr)
      pc_next = {alu_out_reg[XLEN-1:1], 1'b0};
    else if (jal || (cond_branch && br_taken))
      pc_next = pc_plus_imm;
    else
      pc_next = pcn_reg;
  end

  always_comb begin
    if (U_type)
      wb_data = lui ? imm_reg : pc_plus_imm;
    else if (jal || jalr)
      wb_data = pcn_reg;
    else
      wb_data = MemtoReg ? mdr_reg : alu_out_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      pcn_reg     <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      imm_reg     <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
    end else begin
      if (ir_write) begin
        ir_reg  <= instr;
        pcn_reg <= pc_reg + XLEN'(4);
      end
      if (state == S_DECODE) begin
        a_reg   <= rs1_data;
        b_reg   <= rs2_data;
        imm_reg <= imm_ext;
      end
      if (state == S_EXEC) alu_out_reg <= alu_y;
      if (mdr_write) mdr_reg <= Rd_mem_data;
      if (pc_write) pc_reg <= pc_next;
    end
  end

  // x0 is never stored; reads of it are forced to zero above.
  assign rf_write = (state == S_WB) && RegWrite && !rst && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rf_write) rf[rd] <= wb_data;
  end

  assign opcode      = ir_reg[6:0];
  assign func3       = ir_reg[14:12];
  assign func7       = ir_reg[30];
  assign ALU_result  = alu_out_reg;
  assign Wr_mem_data = b_reg;
  assign pc          = pc_reg;
  assign rom_addr    = pc_reg[ROM_AW+1:2];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: a small decoder, instruction ROM and wait-state data memory
// drive the datapath through a hand-encoded program with hand-computed results.
module tb_multicycle_datapath;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ready = 1'b1;
  logic [7:0]  rom_addr;
  logic        MemtoReg, ALUSrc, RegWrite, lui, U_type, jal, jalr;
  logic        beq, bne, blt, bge, bltu, bgeu, MemRead, MemWrite;
  logic [3:0]  ALUctl;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] ALU_result, Wr_mem_data, Rd_mem_data;
  logic        instr_retired;
  logic [31:0] pc;

  logic [31:0] rom  [256];
  logic [31:0] dmem [64];
  int          dmem_delay = 0;
  int          dcnt = 0;
  logic [31:0] last_st_addr = '0;
  logic [31:0] last_st_data = '0;
  int          checks = 0;
  int          errors = 0;

  multicycle_datapath #(.XLEN(32), .ROM_AW(8), .RESET_PC(32'h40)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_req(imem_req), .imem_ready(imem_ready),
    .rom_addr(rom_addr), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .lui(lui), .U_type(U_type), .jal(jal), .jalr(jalr), .beq(beq), .bne(bne),
    .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUctl(ALUctl), .opcode(opcode), .func3(func3),
    .func7(func7), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ALU_result(ALU_result), .Wr_mem_data(Wr_mem_data), .Rd_mem_data(Rd_mem_data),
    .instr_retired(instr_retired), .pc(pc)
  );

  always #5 clk = ~clk;

  assign instr       = rom[rom_addr];
  assign Rd_mem_data = dmem[ALU_result[7:2]];
  assign dmem_ready  = dmem_req && (dcnt >= dmem_delay);

  // Wait-state counter: ready rises dmem_delay cycles after the request does.
  always @(posedge clk) begin
    if (!dmem_req || dmem_ready) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end

  always @(posedge clk) begin
    if (dmem_req && dmem_ready && dmem_we) begin
      dmem[ALU_result[7:2]] <= Wr_mem_data;
      last_st_addr <= ALU_result;
      last_st_data <= Wr_mem_data;
    end
  end

  // Control decoder standing in for the existing one above the datapath.
  always_comb begin
    MemtoReg = 0; ALUSrc = 0; RegWrite = 0; lui = 0; U_type = 0; jal = 0; jalr = 0;
    beq = 0; bne = 0; blt = 0; bge = 0; bltu = 0; bgeu = 0; MemRead = 0; MemWrite = 0;
    ALUctl = ALU_ADD;
    case (opcode)
      OP_LUI:    begin RegWrite = 1; U_type = 1; lui = 1; end
      OP_AUIPC:  begin RegWrite = 1; U_type = 1; end
      OP_JAL:    begin RegWrite = 1; jal = 1; end
      OP_JALR:   begin RegWrite = 1; jalr = 1; ALUSrc = 1; end
      OP_LOAD:   begin RegWrite = 1; MemRead = 1; MemtoReg = 1; ALUSrc = 1; end
      OP_STORE:  begin MemWrite = 1; ALUSrc = 1; end
      OP_BRANCH: begin
        ALUctl = ALU_SUB;
        case (func3)
          3'b000:  beq  = 1;
          3'b001:  bne  = 1;
          3'b100:  blt  = 1;
          3'b101:  bge  = 1;
          3'b110:  bltu = 1;
          default: bgeu = 1;
        endcase
      end
      OP_IMM, OP_REG: begin
        RegWrite = 1;
        ALUSrc   = (opcode == OP_IMM);
        case (func3)
          3'b000:  ALUctl = (opcode == OP_REG && func7) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUctl = ALU_SLL;
          3'b010:  ALUctl = ALU_SLT;
          3'b011:  ALUctl = ALU_SLTU;
          3'b100:  ALUctl = ALU_XOR;
          3'b101:  ALUctl = func7 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUctl = ALU_OR;
          default: ALUctl = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs to the next retire pulse (bounded) and checks its cycle count and new pc.
  task automatic run_instr(input string tag, input int exp_n, input logic [31:0] exp_pc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!instr_retired && n < 20);
    $display("retire %s pc=%h cycles=%0d", tag, pc, n);
    check({tag, " cycles"}, 32'(n), 32'(exp_n));
    check({tag, " pc"}, pc, exp_pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h00000013;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    rom[16] = 32'h00500093;  // 0x40 addi x1,x0,5
    rom[17] = 32'h00108133;  // 0x44 add  x2,x1,x1
    rom[18] = 32'h00202423;  // 0x48 sw   x2,8(x0)
    rom[19] = 32'h00802183;  // 0x4C lw   x3,8(x0)
    rom[20] = 32'h00302623;  // 0x50 sw   x3,12(x0)
    rom[21] = 32'hFCDFF06F;  // 0x54 jal  x0,-52
    rom[6]  = 32'h0080006F;  // 0x18 jal  x0,+8
    rom[8]  = 32'hFE108CE3;  // 0x20 beq  x1,x1,-8
    rom[9]  = 32'h10100313;  // 0x24 addi x6,x0,0x101
    rom[10] = 32'h004302E7;  // 0x28 jalr x5,4(x6)
    rom[65] = 32'h123453B7;  // 0x104 lui x7,0x12345
    rom[66] = 32'h00502823;  // 0x108 sw  x5,16(x0)
    rom[67] = 32'h00702A23;  // 0x10C sw  x7,20(x0)
    rom[68] = 32'h01402183;  // 0x110 lw  x3,20(x0)

    step(2);
    check("rst pc", pc, 32'h40);
    check("rst rom_addr", 32'(rom_addr), 32'h10);
    check("rst imem_req", 32'(imem_req), 0);
    check("rst dmem_req/we", {30'd0, dmem_req, dmem_we}, 0);
    check("rst retired", 32'(instr_retired), 0);
    check("rst ir fields", {21'd0, opcode, func3, func7}, 0);
    check("rst ALU_result", ALU_result, 0);
    check("rst Wr_mem_data", Wr_mem_data, 0);

    rst = 1'b0;
    step(1);
    check("post-rst imem_req", 32'(imem_req), 1);

    run_instr("addi", 4, 32'h44);
    run_instr("add", 4, 32'h48);
    check("retire pulse width", 32'(instr_retired), 1);

    // Store with three data wait states: everything held across four MEM cycles.
    dmem_delay = 3;
    step(3);
    for (int k = 0; k < 4; k++) begin
      check("sw req/we held", {30'd0, dmem_req, dmem_we}, 32'd3);
      check("sw addr held", ALU_result, 32'd8);
      check("sw data held", Wr_mem_data, 32'd10);
      check("sw no retire yet", 32'(instr_retired), 0);
      step(1);
    end
    check("sw retired", 32'(instr_retired), 1);
    check("sw pc", pc, 32'h4C);
    check("sw mem", dmem[2], 32'd10);
    dmem_delay = 0;

    run_instr("lw", 5, 32'h50);
    run_instr("sw x3", 4, 32'h54);
    check("lw value via sw", last_st_data, 32'd10);
    check("sw x3 addr", last_st_addr, 32'd12);

    run_instr("jal", 4, 32'h20);
    run_instr("beq", 3, 32'h18);
    rom[8] = 32'hFE109CE3;   // 0x20 now bne x1,x1,-8
    run_instr("jal fwd", 4, 32'h20);
    run_instr("bne", 3, 32'h24);
    run_instr("addi x6", 4, 32'h28);
    run_instr("jalr", 4, 32'h104);
    run_instr("lui", 4, 32'h108);
    run_instr("sw x5", 4, 32'h10C);
    check("jalr link", last_st_data, 32'h2C);
    run_instr("sw x7", 4, 32'h110);
    check("lui value", last_st_data, 32'h12345000);
    check("sw x7 addr", last_st_addr, 32'd20);

    // Load stalled in MEM, then reset: abandoned with no register or pc update.
    dmem_delay = 100;
    step(3);
    check("lw stall req/we", {30'd0, dmem_req, dmem_we}, 32'd2);
    check("lw stall addr", ALU_result, 32'd20);
    step(2);
    rst = 1'b1;
    step(1);
    check("mid-rst pc", pc, 32'h40);
    check("mid-rst reqs", {29'd0, imem_req, dmem_req, dmem_we}, 0);
    check("mid-rst retired", 32'(instr_retired), 0);
    rom[16] = 32'h00302623;  // 0x40 sw x3,12(x0)
    dmem_delay = 0;
    rst = 1'b0;
    step(1);
    check("refetch imem_req", 32'(imem_req), 1);
    check("refetch rom_addr", 32'(rom_addr), 32'h10);
    run_instr("sw after rst", 4, 32'h44);
    check("x3 untouched", last_st_data, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
